lsu_bus_ctrl: RTL and testbench

- Parametrised successor to the core's combinational load/store unit.
- Sits between the execute stage and the system bus.
- Decodes N_CE chip-enable regions and performs a REQ/GNT handshake only for regions that are arbitrated. Unarbitrated regions keep the single-cycle fast path.
- Adds features the current LSU lacks: registered multi-cycle access, a grant timeout with error reporting, misalignment detection, write-lane replication and load sign/zero extension.
- Drives o_STALL to freeze the decode and execute stages.

---
 rtl/lsu_bus_ctrl_pkg.sv | 21 ++
 rtl/lsu_bus_ctrl_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_ctrl_pkg.sv
// rtl/lsu_bus_ctrl_pkg.sv - shared encodings for the load/store bus controller
package lsu_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Size code 11 falls into the word rule.
    function automatic logic misaligned(input logic [1:0] hb, input logic [1:0] lo);
        case (hb)
            HB_BYTE: return 1'b0;
            HB_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// rtl/lsu_bus_ctrl_if.sv - execute-side and system-bus signals of the load/store controller
interface lsu_bus_ctrl_if #(
    parameter int N_CE = 8
);
    logic            i_RE;
    logic            i_WE;
    logic [1:0]      i_HB;
    logic            i_ULOAD;
    logic [31:0]     i_ADDR;
    logic [31:0]     i_WDATA;
    logic [31:0]     o_RDATA;
    logic            o_STALL;
    logic            o_MISALIGN;
    logic            o_ERR;
    logic [31:0]     o_BUS_ADDR;
    logic [31:0]     o_BUS_WDATA;
    logic            o_BUS_WE;
    logic            o_BUS_RE;
    logic [1:0]      o_BUS_HB;
    logic [N_CE-1:0] o_BUS_CE;
    logic            o_BUS_REQ;
    logic            i_BUS_GNT;
    logic [31:0]     i_BUS_RDATA;

    modport slave (
        input  i_RE, i_WE, i_HB, i_ULOAD, i_ADDR, i_WDATA, i_BUS_GNT, i_BUS_RDATA,
        output o_RDATA, o_STALL, o_MISALIGN, o_ERR, o_BUS_ADDR, o_BUS_WDATA,
               o_BUS_WE, o_BUS_RE, o_BUS_HB, o_BUS_CE, o_BUS_REQ
    );

    modport master (
        output i_RE, i_WE, i_HB, i_ULOAD, i_ADDR, i_WDATA, i_BUS_GNT, i_BUS_RDATA,
        input  o_RDATA, o_STALL, o_MISALIGN, o_ERR, o_BUS_ADDR, o_BUS_WDATA,
               o_BUS_WE, o_BUS_RE, o_BUS_HB, o_BUS_CE, o_BUS_REQ
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication and load lane select/extension
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  hb,
    input  logic        uload,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_bus,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (hb)
            HB_BYTE: begin
                wdata_bus = {4{wdata[7:0]}};
                rdata_ext = uload ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            HB_HALF: begin
                wdata_bus = {2{wdata[15:0]}};
                rdata_ext = uload ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                wdata_bus = wdata;
                rdata_ext = rdata;
            end
        endcase
    end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - region-decoding load/store bus controller with REQ/GNT arbitration
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int              N_CE        = 8,
    parameter int              CE_LSB      = 28,
    parameter int              CE_MSB      = 30,
    parameter logic [N_CE-1:0] ARB_MASK    = N_CE'(8'h0F),
    parameter int              TIMEOUT_CYC = 255
) (
    input logic           i_CLK,
    input logic           i_RST,
    lsu_bus_ctrl_if.slave bus
);
    localparam int CEW = CE_MSB - CE_LSB + 1;

    logic [1:0]      state;
    logic [31:0]     cnt;
    logic            err_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      hb_q;
    logic            uload_q;
    logic            re_q;
    logic            we_q;
    logic [N_CE-1:0] ce_q;
    logic [31:0]     rdata_q;

    logic [CEW-1:0]  idx;
    logic [N_CE-1:0] ce_dec;
    logic            req, mis, mapped, arb, in_req, timeout;
    logic [31:0]     cnt_inc;
    logic [1:0]      al_hb, al_lo;
    logic            al_uload;
    logic [31:0]     al_wdata, al_wbus, al_rext;

    assign idx = bus.i_ADDR[CE_MSB:CE_LSB];

    always_comb begin
        ce_dec = '0;
        for (int i = 0; i < N_CE; i++) ce_dec[i] = (int'(idx) == i);
    end

    assign req     = bus.i_RE | bus.i_WE;
    assign mis     = req && misaligned(bus.i_HB, bus.i_ADDR[1:0]);
    assign mapped  = |ce_dec;
    assign arb     = |(ce_dec & ARB_MASK);
    assign in_req  = (state == REQ);
    assign cnt_inc = cnt + 32'd1;
    assign timeout = (TIMEOUT_CYC != 0) && (cnt_inc == 32'(TIMEOUT_CYC));

    // One aligner serves both the fast path (live inputs) and REQ (latched copy).
    assign al_hb    = in_req ? hb_q        : bus.i_HB;
    assign al_lo    = in_req ? addr_q[1:0] : bus.i_ADDR[1:0];
    assign al_uload = in_req ? uload_q     : bus.i_ULOAD;
    assign al_wdata = in_req ? wdata_q     : bus.i_WDATA;

    lsu_lane_align u_align (
        .hb        (al_hb),
        .uload     (al_uload),
        .addr_lo   (al_lo),
        .wdata     (al_wdata),
        .rdata     (bus.i_BUS_RDATA),
        .wdata_bus (al_wbus),
        .rdata_ext (al_rext)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hb_q    <= '0;
            uload_q <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ce_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !mis && arb) begin
                        addr_q  <= bus.i_ADDR;
                        wdata_q <= bus.i_WDATA;
                        hb_q    <= bus.i_HB;
                        uload_q <= bus.i_ULOAD;
                        re_q    <= bus.i_RE & ~bus.i_WE;
                        we_q    <= bus.i_WE;
                        ce_q    <= ce_dec;
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (bus.i_BUS_GNT) begin
                        rdata_q <= we_q ? 32'd0 : al_rext;
                        state   <= DONE;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.o_RDATA     = '0;
        bus.o_STALL     = 1'b0;
        bus.o_MISALIGN  = 1'b0;
        bus.o_ERR       = 1'b0;
        bus.o_BUS_ADDR  = '0;
        bus.o_BUS_WDATA = '0;
        bus.o_BUS_WE    = 1'b0;
        bus.o_BUS_RE    = 1'b0;
        bus.o_BUS_HB    = '0;
        bus.o_BUS_CE    = '0;
        bus.o_BUS_REQ   = 1'b0;
        case (state)
            IDLE: begin
                if (mis) begin
                    bus.o_MISALIGN = 1'b1;
                end else if (req && !mapped) begin
                    bus.o_ERR = 1'b1;
                end else if (req && arb) begin
                    bus.o_STALL = 1'b1;
                end else if (req) begin
                    bus.o_RDATA     = al_rext;
                    bus.o_BUS_ADDR  = {bus.i_ADDR[31:2], 2'b00};
                    bus.o_BUS_WDATA = al_wbus;
                    bus.o_BUS_WE    = bus.i_WE;
                    bus.o_BUS_RE    = bus.i_RE & ~bus.i_WE;
                    bus.o_BUS_HB    = bus.i_HB;
                    bus.o_BUS_CE    = ce_dec;
                end
            end
            REQ: begin
                bus.o_STALL     = 1'b1;
                bus.o_BUS_REQ   = 1'b1;
                bus.o_BUS_ADDR  = {addr_q[31:2], 2'b00};
                bus.o_BUS_WDATA = al_wbus;
                bus.o_BUS_WE    = we_q;
                bus.o_BUS_RE    = re_q;
                bus.o_BUS_HB    = hb_q;
                bus.o_BUS_CE    = ce_q;
            end
            DONE: begin
                bus.o_RDATA = rdata_q;
                bus.o_ERR   = err_q;
            end
            default: ;
        endcase
        // Outputs are forced quiet while reset is held, including mid-transaction.
        if (i_RST) begin
            bus.o_RDATA     = '0;
            bus.o_STALL     = 1'b0;
            bus.o_MISALIGN  = 1'b0;
            bus.o_ERR       = 1'b0;
            bus.o_BUS_ADDR  = '0;
            bus.o_BUS_WDATA = '0;
            bus.o_BUS_WE    = 1'b0;
            bus.o_BUS_RE    = 1'b0;
            bus.o_BUS_HB    = '0;
            bus.o_BUS_CE    = '0;
            bus.o_BUS_REQ   = 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - directed self-checking bench for lsu_bus_ctrl
module tb_lsu_bus_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lsu_bus_ctrl_if #(.N_CE(8)) bif ();

    lsu_bus_ctrl #(
        .N_CE        (8),
        .CE_LSB      (28),
        .CE_MSB      (30),
        .ARB_MASK    (8'h0F),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic re, input logic we, input logic [1:0] hb, input logic uload,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        bif.i_RE        = re;
        bif.i_WE        = we;
        bif.i_HB        = hb;
        bif.i_ULOAD     = uload;
        bif.i_ADDR      = addr;
        bif.i_WDATA     = wdata;
        bif.i_BUS_RDATA = rdata;
    endtask

    // Runs one arbitrated transaction from IDLE to DONE; gnt_at=0 never grants.
    task automatic run_arb(input int gnt_at, output int stall_n, output int req_n,
                           output logic [31:0] rd, output logic err, output logic [31:0] b_addr,
                           output logic [31:0] b_wdata, output logic [1:0] b_hb,
                           output logic b_we, output logic [7:0] b_ce);
        bit done = 0;
        stall_n = 0; req_n = 0; rd = '0; err = 1'b0;
        b_addr = '0; b_wdata = '0; b_hb = '0; b_we = 1'b0; b_ce = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (bif.o_STALL) stall_n++;
            if (bif.o_BUS_REQ) begin
                req_n++;
                b_addr = bif.o_BUS_ADDR; b_wdata = bif.o_BUS_WDATA;
                b_hb = bif.o_BUS_HB; b_we = bif.o_BUS_WE; b_ce = bif.o_BUS_CE;
            end
            if (!bif.o_STALL && stall_n > 0) begin
                rd = bif.o_RDATA; err = bif.o_ERR; done = 1;
                bif.i_RE = 1'b0; bif.i_WE = 1'b0; bif.i_BUS_GNT = 1'b0;
            end else begin
                bif.i_BUS_GNT = (gnt_at != 0 && req_n == gnt_at);
                @(negedge clk);
            end
        end
        check("arb_bound", {31'd0, done}, 32'd1);
    endtask

    int          sn, rn;
    logic [31:0] rd, ba, bw;
    logic        er, bwe;
    logic [1:0]  bhb;
    logic [7:0]  bce;

    initial begin
        bif.i_BUS_GNT = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        check("rst_rdata", bif.o_RDATA, 32'h0);
        check("rst_ce", {24'd0, bif.o_BUS_CE}, 32'h0);
        check("rst_re", {31'd0, bif.o_BUS_RE}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'h1234_5678, 32'hDEAD_BEEF);
        #1;
        check("idle_addr", bif.o_BUS_ADDR, 32'h0);
        check("idle_wdata", bif.o_BUS_WDATA, 32'h0);

        // Fast path word load
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF);
        #1;
        check("fast_rdata", bif.o_RDATA, 32'hDEAD_BEEF);
        check("fast_ce", {24'd0, bif.o_BUS_CE}, 32'h10);
        check("fast_req", {31'd0, bif.o_BUS_REQ}, 32'h0);
        check("fast_stall", {31'd0, bif.o_STALL}, 32'h0);
        check("fast_re", {31'd0, bif.o_BUS_RE}, 32'h1);
        // Fast byte/half loads and stores
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h5000_0001, 32'h0, 32'h0000_8000);
        #1; check("fast_sbyte", bif.o_RDATA, 32'hFFFF_FF80);
        bif.i_ULOAD = 1'b1;
        #1; check("fast_ubyte", bif.o_RDATA, 32'h0000_0080);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h6000_0002, 32'h0, 32'h8001_0000);
        #1; check("fast_shalf", bif.o_RDATA, 32'hFFFF_8001);
        drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h7000_0003, 32'h1234_5678, 32'h0);
        #1;
        check("fast_bstore_wdata", bif.o_BUS_WDATA, 32'h7878_7878);
        check("fast_both_we", {31'd0, bif.o_BUS_WE}, 32'h1);
        check("fast_both_re", {31'd0, bif.o_BUS_RE}, 32'h0);
        check("fast_bstore_addr", bif.o_BUS_ADDR, 32'h7000_0000);
        @(negedge clk);

        // Arbitrated signed byte load, grant in third REQ cycle
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000_0003, 32'h0, 32'h80FF_FFFF);
        run_arb(3, sn, rn, rd, er, ba, bw, bhb, bwe, bce);
        check("arb_stall_cycles", sn, 32'd4);
        check("arb_req_cycles", rn, 32'd3);
        check("arb_sbyte", rd, 32'hFFFF_FF80);
        check("arb_ce", {24'd0, bce}, 32'h02);
        check("arb_err", {31'd0, er}, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h1000_0003, 32'h0, 32'h80FF_FFFF);
        run_arb(3, sn, rn, rd, er, ba, bw, bhb, bwe, bce);
        check("arb_ubyte", rd, 32'h0000_0080);
        @(negedge clk);

        // Arbitrated half store, immediate grant
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h2000_0002, 32'h0000_ABCD, 32'h5555_5555);
        run_arb(1, sn, rn, rd, er, ba, bw, bhb, bwe, bce);
        check("st_wdata", bw, 32'hABCD_ABCD);
        check("st_hb", {30'd0, bhb}, 32'h1);
        check("st_we", {31'd0, bwe}, 32'h1);
        check("st_addr", ba, 32'h2000_0000);
        check("st_rdata", rd, 32'h0);
        check("st_stall_cycles", sn, 32'd2);
        @(negedge clk);

        // Misaligned word load
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000_0002, 32'h0, 32'hFFFF_FFFF);
        #1;
        check("mis_pulse", {31'd0, bif.o_MISALIGN}, 32'h1);
        check("mis_ce", {24'd0, bif.o_BUS_CE}, 32'h0);
        check("mis_req", {31'd0, bif.o_BUS_REQ}, 32'h0);
        check("mis_stall", {31'd0, bif.o_STALL}, 32'h0);
        check("mis_rdata", bif.o_RDATA, 32'h0);
        @(negedge clk);
        bif.i_RE = 1'b0;
        #1;
        check("mis_drop", {31'd0, bif.o_MISALIGN}, 32'h0);
        check("mis_no_fsm", {31'd0, bif.o_STALL}, 32'h0);
        @(negedge clk);

        // Grant timeout
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h3000_0004, 32'h0, 32'h1111_1111);
        run_arb(0, sn, rn, rd, er, ba, bw, bhb, bwe, bce);
        check("to_req_cycles", rn, 32'd16);
        check("to_err", {31'd0, er}, 32'h1);
        check("to_rdata", rd, 32'h0);
        @(negedge clk); #1;
        check("to_err_pulse", {31'd0, bif.o_ERR}, 32'h0);
        check("to_idle", {31'd0, bif.o_STALL}, 32'h0);
        @(negedge clk);

        // Reset during second REQ cycle
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'h0, 32'h2222_2222);
        #1; check("rst_idle_stall", {31'd0, bif.o_STALL}, 32'h1);
        @(negedge clk); @(negedge clk); #1;
        check("rst_before_req", {31'd0, bif.o_BUS_REQ}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_req_drop", {31'd0, bif.o_BUS_REQ}, 32'h0);
        check("rst_stall_drop", {31'd0, bif.o_STALL}, 32'h0);
        check("rst_no_err", {31'd0, bif.o_ERR}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000_0020, 32'h0, 32'h1234_5678);
        #1;
        check("post_rst_rdata", bif.o_RDATA, 32'h1234_5678);
        check("post_rst_stall", {31'd0, bif.o_STALL}, 32'h0);
        @(negedge clk);
        bif.i_RE = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
